// File: rtl/kronos_decode.sv
`default_nettype none
// ------------------------------------------------------------------------
// kronos_decode: RV32I decode stage with register file, bypass and RAW scoreboard
// Revision: 1.0
// ------------------------------------------------------------------------
module kronos_decode #(
  parameter bit FAST_REGFILE  = 1'b0,
  parameter bit BYPASS        = 1'b1,
  parameter bit CATCH_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_ir,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] decode_op1,
  output logic [31:0] decode_op2,
  output logic [31:0] decode_imm,
  output logic [31:0] decode_rs2_data,
  output logic [4:0]  decode_rd,
  output logic        decode_rd_write,
  output logic [7:0]  decode_alu,
  output logic [3:0]  decode_class,
  output logic [2:0]  decode_funct3,
  output logic        decode_illegal,
  output logic        pipe_out_vld,
  input  logic        pipe_out_rdy,
  input  logic [31:0] regwr_data,
  input  logic [4:0]  regwr_sel,
  input  logic        regwr_en
);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_AND   = 3'd1;
  localparam logic [2:0] c_ALU_OR    = 3'd2;
  localparam logic [2:0] c_ALU_XOR   = 3'd3;
  localparam logic [2:0] c_ALU_COMP  = 3'd4;
  localparam logic [2:0] c_ALU_SHIFT = 3'd5;

  localparam logic [1:0] c_OP1_RS1  = 2'd0;
  localparam logic [1:0] c_OP1_PC   = 2'd1;
  localparam logic [1:0] c_OP1_ZERO = 2'd2;
  localparam logic [1:0] c_OP2_IMM  = 2'd0;
  localparam logic [1:0] c_OP2_RS2  = 2'd1;
  localparam logic [1:0] c_OP2_FOUR = 2'd2;

  typedef enum logic [0:0] {ID1 = 1'b0, ID2 = 1'b1} state_t;

  logic [31:0] r_regs [0:31];
  logic [31:0] r_sb;
  state_t      r_state;

  logic [31:0] r_op1, r_op2, r_imm, r_rs2_data;
  logic [4:0]  r_rd;
  logic        r_rd_write, r_illegal, r_vld;
  logic [7:0]  r_alu;
  logic [3:0]  r_class;
  logic [2:0]  r_funct3;
  logic [31:0] r_rs1_q, r_rs2_q, r_pc_q;
  logic [1:0]  r_op1_sel, r_op2_sel;

  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm, w_rs1_data, w_rs2_data, w_clr, w_set, w_sb_pend;
  logic        w_use_rs1, w_use_rs2, w_wr_class, w_bad, w_arith;
  logic        w_illegal, w_rd_write, w_hazard, w_in_rdy, w_accept;
  logic [1:0]  w_op1_sel, w_op2_sel;
  logic [3:0]  w_class;
  logic        w_neg, w_rev, w_cin, w_uns, w_gte;
  logic [2:0]  w_sel;
  logic [7:0]  w_alu;

  assign w_opc = fetch_ir[6:0];
  assign w_rd  = fetch_ir[11:7];
  assign w_f3  = fetch_ir[14:12];
  assign w_rs1 = fetch_ir[19:15];
  assign w_rs2 = fetch_ir[24:20];
  assign w_f7  = fetch_ir[31:25];

  assign w_imm_i = {{21{fetch_ir[31]}}, fetch_ir[30:20]};
  assign w_imm_s = {{21{fetch_ir[31]}}, fetch_ir[30:25], fetch_ir[11:7]};
  assign w_imm_b = {{20{fetch_ir[31]}}, fetch_ir[7], fetch_ir[30:25], fetch_ir[11:8], 1'b0};
  assign w_imm_u = {fetch_ir[31:12], 12'b0};
  assign w_imm_j = {{12{fetch_ir[31]}}, fetch_ir[19:12], fetch_ir[20], fetch_ir[30:21], 1'b0};

  always_comb begin
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_wr_class = 1'b0;
    w_bad      = 1'b0;
    w_arith    = 1'b0;
    w_imm      = w_imm_i;
    w_op1_sel  = c_OP1_RS1;
    w_op2_sel  = c_OP2_IMM;
    w_class    = 4'b0000;
    w_neg = 1'b0; w_rev = 1'b0; w_cin = 1'b0; w_uns = 1'b0; w_gte = 1'b0;
    w_sel = c_ALU_ADD;
    case (w_opc)
      c_OPC_LUI:   begin w_wr_class = 1'b1; w_imm = w_imm_u; w_op1_sel = c_OP1_ZERO; end
      c_OPC_AUIPC: begin w_wr_class = 1'b1; w_imm = w_imm_u; w_op1_sel = c_OP1_PC; end
      c_OPC_JAL: begin
        w_wr_class = 1'b1; w_imm = w_imm_j; w_op1_sel = c_OP1_PC;
        w_op2_sel  = c_OP2_FOUR; w_class = 4'b0100;
      end
      c_OPC_JALR: begin
        w_wr_class = 1'b1; w_use_rs1 = 1'b1; w_op2_sel = c_OP2_FOUR;
        w_class    = 4'b0100; w_bad = (w_f3 != 3'b000);
      end
      c_OPC_BRANCH: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b;
        w_op2_sel = c_OP2_RS2; w_class = 4'b1000;
        w_bad     = (w_f3[2:1] == 2'b01);
        // Equality compares through XOR; ordered compares subtract
        if (w_f3[2]) begin
          w_neg = 1'b1; w_cin = 1'b1; w_sel = c_ALU_COMP;
          w_gte = w_f3[0]; w_uns = w_f3[1];
        end else begin
          w_sel = c_ALU_XOR;
        end
      end
      c_OPC_LOAD: begin
        w_wr_class = 1'b1; w_use_rs1 = 1'b1; w_class = 4'b0001;
        w_bad      = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      c_OPC_STORE: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_s;
        w_class   = 4'b0010; w_bad = (w_f3 > 3'd2);
      end
      c_OPC_OPIMM: begin
        w_wr_class = 1'b1; w_use_rs1 = 1'b1; w_arith = 1'b1;
        if (w_f3 == 3'b001) w_bad = (w_f7 != 7'b0000000);
        if (w_f3 == 3'b101) w_bad = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
      end
      c_OPC_OP: begin
        w_wr_class = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_op2_sel  = c_OP2_RS2; w_arith = 1'b1;
        w_bad = !((w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      c_OPC_MISC, c_OPC_SYSTEM: ;
      default: w_bad = 1'b1;
    endcase
    if (w_opc[1:0] != 2'b11) w_bad = 1'b1;
    if (w_arith) begin
      case (w_f3)
        3'b000: begin w_neg = (w_opc == c_OPC_OP) && w_f7[5]; w_cin = w_neg; end
        3'b001: begin w_sel = c_ALU_SHIFT; w_rev = 1'b1; end
        3'b010: begin w_neg = 1'b1; w_cin = 1'b1; w_sel = c_ALU_COMP; end
        3'b011: begin w_neg = 1'b1; w_cin = 1'b1; w_uns = 1'b1; w_sel = c_ALU_COMP; end
        3'b100: w_sel = c_ALU_XOR;
        3'b101: begin w_sel = c_ALU_SHIFT; w_cin = w_f7[5]; end
        3'b110: w_sel = c_ALU_OR;
        default: w_sel = c_ALU_AND;
      endcase
    end
  end

  assign w_alu      = {w_neg, w_rev, w_cin, w_uns, w_gte, w_sel};
  assign w_illegal  = CATCH_ILLEGAL & w_bad;
  assign w_rd_write = w_wr_class && (w_rd != 5'd0) && !w_illegal;

  assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                      (BYPASS && regwr_en && (regwr_sel == w_rs1)) ? regwr_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                      (BYPASS && regwr_en && (regwr_sel == w_rs2)) ? regwr_data : r_regs[w_rs2];

  assign w_clr     = regwr_en ? (32'd1 << regwr_sel) : 32'd0;
  assign w_sb_pend = BYPASS ? (r_sb & ~w_clr) : r_sb;
  assign w_hazard  = (w_use_rs1 && w_sb_pend[w_rs1]) || (w_use_rs2 && w_sb_pend[w_rs2]);
  assign w_in_rdy  = (r_state == ID1) && (!r_vld || pipe_out_rdy) && !w_hazard;
  assign w_accept  = pipe_in_vld && w_in_rdy;
  assign w_set     = (w_accept && w_rd_write) ? (32'd1 << w_rd) : 32'd0;

  function automatic logic [31:0] op1_mux(input logic [1:0] sel, input logic [31:0] pc,
                                          input logic [31:0] rs);
    case (sel)
      c_OP1_ZERO: op1_mux = 32'd0;
      c_OP1_PC:   op1_mux = pc;
      default:    op1_mux = rs;
    endcase
  endfunction

  function automatic logic [31:0] op2_mux(input logic [1:0] sel, input logic [31:0] rs,
                                          input logic [31:0] imm);
    case (sel)
      c_OP2_RS2:  op2_mux = rs;
      c_OP2_FOUR: op2_mux = 32'd4;
      default:    op2_mux = imm;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (regwr_en && (regwr_sel != 5'd0)) r_regs[regwr_sel] <= regwr_data;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_sb       <= 32'd0;
      r_state    <= ID1;
      r_vld      <= 1'b0;
      r_op1      <= 32'd0;
      r_op2      <= 32'd0;
      r_imm      <= 32'd0;
      r_rs2_data <= 32'd0;
      r_rd       <= 5'd0;
      r_rd_write <= 1'b0;
      r_alu      <= 8'd0;
      r_class    <= 4'd0;
      r_funct3   <= 3'd0;
      r_illegal  <= 1'b0;
      r_rs1_q    <= 32'd0;
      r_rs2_q    <= 32'd0;
      r_pc_q     <= 32'd0;
      r_op1_sel  <= c_OP1_RS1;
      r_op2_sel  <= c_OP2_IMM;
    end else begin
      // A set landing on the same register as a clear must win
      r_sb <= (r_sb & ~w_clr) | w_set;
      if (FAST_REGFILE) begin
        if (w_accept) begin
          r_op1      <= op1_mux(w_op1_sel, fetch_pc, w_rs1_data);
          r_op2      <= op2_mux(w_op2_sel, w_rs2_data, w_imm);
          r_imm      <= w_imm;
          r_rs2_data <= w_rs2_data;
          r_rd       <= w_rd_write ? w_rd : 5'd0;
          r_rd_write <= w_rd_write;
          r_alu      <= w_alu;
          r_class    <= w_class;
          r_funct3   <= w_f3;
          r_illegal  <= w_illegal;
          r_vld      <= 1'b1;
        end else if (pipe_out_rdy) begin
          r_vld <= 1'b0;
        end
      end else begin
        case (r_state)
          ID1: begin
            if (pipe_out_rdy) r_vld <= 1'b0;
            if (w_accept) begin
              r_imm      <= w_imm;
              r_rd       <= w_rd_write ? w_rd : 5'd0;
              r_rd_write <= w_rd_write;
              r_alu      <= w_alu;
              r_class    <= w_class;
              r_funct3   <= w_f3;
              r_illegal  <= w_illegal;
              r_rs1_q    <= w_rs1_data;
              r_rs2_q    <= w_rs2_data;
              r_pc_q     <= fetch_pc;
              r_op1_sel  <= w_op1_sel;
              r_op2_sel  <= w_op2_sel;
              r_state    <= ID2;
            end
          end
          default: begin
            r_op1      <= op1_mux(r_op1_sel, r_pc_q, r_rs1_q);
            r_op2      <= op2_mux(r_op2_sel, r_rs2_q, r_imm);
            r_rs2_data <= r_rs2_q;
            r_vld      <= 1'b1;
            r_state    <= ID1;
          end
        endcase
      end
    end
  end

  assign pipe_in_rdy     = w_in_rdy;
  assign pipe_out_vld    = r_vld;
  assign decode_op1      = r_op1;
  assign decode_op2      = r_op2;
  assign decode_imm      = r_imm;
  assign decode_rs2_data = r_rs2_data;
  assign decode_rd       = r_rd;
  assign decode_rd_write = r_rd_write;
  assign decode_alu      = r_alu;
  assign decode_class    = r_class;
  assign decode_funct3   = r_funct3;
  assign decode_illegal  = r_illegal;

endmodule
`default_nettype wire
